// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4: registered 4-way round-robin arbiter, one-hot gnt.
// Ports: clk, rst_n, en, req[3:0] -> gnt[3:0], gnt_valid, gnt_change.
// Optional hold timeout enabled by defining RR_ARB_HOLD_TIMEOUT_EN.
module rr_arbiter_4 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic       gnt_valid,
  output logic       gnt_change
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD - 1);

  state_t     state, nstate;
  logic [1:0] ptr, nptr;
  logic [1:0] gidx, ngidx;
  logic [7:0] hold_cnt, nhold;
  logic [3:0] ngnt;
  logic [3:0] others;
  logic [2:0] first;
  logic [2:0] excl;

  // {found, index} of first set bit of r, searching s, s+1, ... mod 4
  function automatic logic [2:0] pick(
    input logic [3:0] r,
    input logic [1:0] s
  );
    logic       f;
    logic [1:0] i;
    logic [1:0] idx;
    f   = 1'b0;
    idx = s;
    // walk backwards so the earliest hit in search order wins
    for (int k = 3; k >= 0; k--) begin
      i = s + 2'(k);
      if (r[i]) begin
        f   = 1'b1;
        idx = i;
      end
    end
    return {f, idx};
  endfunction

  assign others = req & ~(4'b0001 << gidx);
  assign first  = pick(req, ptr);
  assign excl   = pick(others, gidx + 2'd1);

  always_comb begin
    nstate = state;
    nptr   = ptr;
    ngidx  = gidx;
    nhold  = hold_cnt;
    unique case (state)
      IDLE: begin
        if (en && (|req)) begin
          nstate = GRANT;
          ngidx  = first[1:0];
          nhold  = 8'd0;
        end
      end
      GRANT: begin
        if (!en) begin
          nstate = IDLE;
        end else if (!req[gidx]) begin
          nptr = gidx + 2'd1;
          if (excl[2]) begin
            ngidx = excl[1:0];
            nhold = 8'd0;
          end else begin
            nstate = IDLE;
          end
`ifdef RR_ARB_HOLD_TIMEOUT_EN
        end else if (hold_cnt == HOLD_MAX && excl[2]) begin
          nptr  = gidx + 2'd1;
          ngidx = excl[1:0];
          nhold = 8'd0;
`endif
        end else if (hold_cnt != HOLD_MAX) begin
          nhold = hold_cnt + 8'd1;
        end
      end
      default: nstate = IDLE;
    endcase
    ngnt = (nstate == GRANT) ? (4'b0001 << ngidx) : 4'b0000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= 2'd0;
      gidx       <= 2'd0;
      hold_cnt   <= 8'd0;
      gnt        <= 4'b0000;
      gnt_valid  <= 1'b0;
      gnt_change <= 1'b0;
    end else begin
      state      <= nstate;
      ptr        <= nptr;
      gidx       <= ngidx;
      hold_cnt   <= nhold;
      gnt        <= ngnt;
      gnt_valid  <= |ngnt;
      gnt_change <= (ngnt != gnt);
    end
  end

endmodule

// File: doc/rr_arbiter_4.md
Name: rr_arbiter_4

Overview:
Registered 4-requester round-robin arbiter that produces the one-hot request vector consumed directly by the 4-to-2 encoder stage.
- Output guarantee: gnt is always exactly one-hot or all-zero, so the encoder never sees a multi-hot or default-case input.
- Fairness: rotating priority with an optional hold timeout.

Parameters:
MAX_HOLD, 8, max consecutive cycles one requester may keep the grant while others wait (only used with the optional feature; legal range 1..255)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
en  input  1  arbitration enable; low forces grant release
req  input  4  request lines, bit i = requester i, level-sensitive
gnt  output  4  registered one-hot grant, 4'b0000 when idle
gnt_valid  output  1  high when gnt is non-zero (equals |gnt, registered)
gnt_change  output  1  one-cycle pulse on the cycle gnt takes a new value, including a change to 4'b0000

Behaviour:
- Reset (rst_n low, async): gnt=4'b0000, gnt_valid=0, gnt_change=0, state=IDLE, ptr=2'd0, hold_cnt=0. Takes effect immediately regardless of clk.
- ptr is the index of the highest-priority requester. Search order: ptr, ptr+1, ptr+2, ptr+3, mod 4 (wraps 3->0).
- State IDLE:
  - en=1 and req!=0: next edge, gnt = one-hot of first requester in search order; state=GRANT; hold_cnt=0.
  - Otherwise stay IDLE with gnt=0.
  - Latency: request to grant is 1 cycle.
- State GRANT (granted index g):
  - en=0: next edge gnt=0, state=IDLE; ptr unchanged.
  - req[g]=0 (release): same edge, ptr=g+1 mod 4, then search req excluding bit g starting from g+1.
    - Found: gnt=that requester, stay GRANT, hold_cnt=0 (direct handoff, no idle gap).
    - None: gnt=0, state=IDLE.
  - req[g]=1 and not timed out: gnt held, hold_cnt increments, saturating at MAX_HOLD-1.
- Simultaneous release by g and new request by g in the same cycle: treated as release. g is excluded from that edge's search.
- Requests arriving while another requester holds the grant wait; the grant is never pre-empted except by timeout.
- gnt_change=1 on the cycle following any edge where gnt's registered value changed, else 0.
- gnt_valid is registered together with gnt; never high with gnt=0.
- Invariant: $countones(gnt) <= 1 in every cycle; assert in verification.
- hold_cnt width: 8 bits.
- Reset mid-grant: all outputs clear asynchronously. After rst_n deasserts, arbitration restarts from ptr=0 on the first edge.

Optional Feature:
RR_ARB_HOLD_TIMEOUT_EN
- Defined: in GRANT, if hold_cnt==MAX_HOLD-1, req[g]=1 and any other req bit is set, the next edge forces rotation.
  - ptr=g+1, gnt=next requester in search order excluding g, hold_cnt=0.
  - If no other requester is pending, g keeps the grant and hold_cnt stays saturated.
- Undefined: no timeout logic. The grant is held indefinitely while req[g]=1 and en=1; MAX_HOLD is ignored.

Test Plan:
1. Reset, then en=1, req=4'b0101 -> one cycle later gnt=4'b0001, gnt_valid=1, gnt_change pulses once.
2. From test 1, drop req[0] (req=4'b0100) -> next cycle gnt=4'b0100 with no zero gap; ptr=1; drop req[2] -> gnt=4'b0000, gnt_valid=0, gnt_change pulse.
3. Timeout defined, MAX_HOLD=4, req=4'b1111 held -> gnt sequence 0001 x4, 0010 x4, 0100 x4, 1000 x4, then 0001 (wrap).
4. Timeout undefined, req=4'b1111 held for 50 cycles -> gnt stays 4'b0001 throughout; gnt_change pulses exactly once.
5. Grant 4'b0010 active, en driven low -> next cycle gnt=0; en high again with req=4'b1010 -> gnt=4'b0010 (ptr preserved at 1).
6. Grant 4'b1000 active, pulse rst_n low between clock edges -> gnt=0 and gnt_valid=0 immediately. After release with req=4'b1001 -> gnt=4'b0001 (ptr reset to 0).
